demux_dispatch_1to2: RTL
========================

Name: demux_dispatch_1to2

Overview:
Buffered, handshaked 1-to-2 stream dispatcher that sits directly upstream of the combinational 1x2 demultiplexer stage and absorbs its backpressure problem.
- Accepts a single valid/ready input stream.
- Chooses a destination per beat, either from an explicit destination bit or by strict round-robin.
- Queues each beat in a per-output FIFO and presents two independent valid/ready output streams.
- Replaces bare select-steering wherever downstream consumers can stall.

Parameters:
WIDTH, 8, data width in bits of input and both outputs
DEPTH, 4, entries per output FIFO; power of two, >= 2

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat present
in_ready  output  1  dispatcher can accept the current beat
in_data  input  WIDTH  input payload
in_dest  input  1  destination (0 -> out0, 1 -> out1); used when rr_en=0
rr_en  input  1  1 = round-robin destination, 0 = in_dest destination
out0_valid  output  1  FIFO0 non-empty
out0_ready  input  1  consumer 0 accepts head beat
out0_data  output  WIDTH  FIFO0 head
out1_valid  output  1  FIFO1 non-empty
out1_ready  input  1  consumer 1 accepts head beat
out1_data  output  WIDTH  FIFO1 head
count0  output  $clog2(DEPTH)+1  FIFO0 occupancy, 0..DEPTH
count1  output  $clog2(DEPTH)+1  FIFO1 occupancy, 0..DEPTH

Behaviour:
- Reset (async assert, sync-safe deassert):
  - both FIFOs emptied, count0=count1=0, out0_valid=out1_valid=0
  - storage cleared, so out0_data=out1_data=0
  - round-robin pointer rr_ptr=0
  - in_ready=1 while out of reset with empty FIFOs
  - reset mid-operation discards all queued beats; no beat is emitted afterwards from pre-reset data
- Destination: dest = rr_en ? rr_ptr : in_dest; purely combinational.
- Ready: in_ready = !full(dest), where full means count==DEPTH.
  - in_ready must not depend combinationally on out0_ready or out1_ready.
  - A full FIFO therefore refuses a push even if it pops in the same cycle.
- Accept: in_valid & in_ready at a rising edge writes in_data to the tail of FIFO[dest].
- Round-robin: rr_ptr toggles only on an accepted beat, and only when rr_en=1.
  - Strict alternation: if FIFO[rr_ptr] is full, input stalls even if the other FIFO has space; no skipping.
  - Toggling rr_en preserves rr_ptr; the new mode applies from the current cycle's dest computation.
- Output (first-word fall-through):
  - outX_valid = (countX != 0); outX_data = head entry.
  - Pop on outX_valid & outX_ready at the edge.
- Latency: a beat accepted at edge N appears on outX_valid/outX_data in the cycle after edge N, i.e. 1 cycle minimum.
- Ordering: per-output order equals input order among beats sent to that output. No drops, no duplication.
- Simultaneous push and pop on the same non-full, non-empty FIFO: count unchanged, both take effect.
- Push to an empty FIFO with outX_ready=1: no same-cycle bypass; the beat pops no earlier than the next edge.
- outX_ready while outX_valid=0: ignored, state unchanged.
- The two FIFOs are fully independent: a stall on one output never blocks pops on the other.
- Pointer arithmetic: read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by a separate counter.
- Data values held at out ports while valid=0: don't-care after the first write, except the post-reset 0.

Test Plan:
- Reset then idle, rr_en=0, WIDTH=8, DEPTH=4 -> in_ready=1, both valid=0, data=0, counts=0; assert rst_n low mid-stream with count0=3 -> counts 0, valid 0 immediately (async).
- rr_en=0, push 0x11,0x22 to dest0 and 0x33 to dest1 with both readies=1 -> out0 emits 0x11 then 0x22, out1 emits 0x33; each appears one cycle after acceptance.
- rr_en=0, out0_ready=0, push 5 beats to dest0 -> first 4 accepted, count0=4, in_ready=0 on the 5th. Raise out0_ready for one cycle -> count0=3, then the 5th beat is accepted next cycle.
- rr_en=1, both readies=1, push 0xA0..0xA5 -> out0 gets A0,A2,A4 and out1 gets A1,A3,A5; rr_ptr ends at 0.
- rr_en=1, out1_ready=0, continuous input -> after FIFO1 fills (4 beats to out1, 4 or 5 to out0), input stalls on rr_ptr=1 while FIFO0 drains fully; no beat is skipped to out0.
- Full FIFO0 with simultaneous in_valid to dest0 and out0_ready=1 -> pop occurs, push refused (in_ready=0), count0 goes 4->3. A concurrent push/pop at count0=2 keeps count0=2 with the pointers wrapping correctly over 10+ beats.

Source files
------------

// File: rtl/demux_dispatch_1to2.sv
// Buffered 1-to-2 stream dispatcher: per-beat destination select,
// one FWFT FIFO per output, independent valid/ready on each side.
module demux_dispatch_1to2 #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_dest,
   input  logic                     rr_en,
   output logic                     out0_valid,
   input  logic                     out0_ready,
   output logic [WIDTH-1:0]         out0_data,
   output logic                     out1_valid,
   input  logic                     out1_ready,
   output logic [WIDTH-1:0]         out1_data,
   output logic [$clog2(DEPTH):0]   count0,
   output logic [$clog2(DEPTH):0]   count1
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic             r_rr;
   logic             w_dest;
   logic [1:0]       w_full;
   logic [1:0]       w_ordy;
   logic [CW-1:0]    w_cnt  [2];
   logic [WIDTH-1:0] w_head [2];

   assign w_dest   = rr_en ? r_rr : in_dest;
   assign w_ordy   = {out1_ready, out0_ready};
   // Ready looks only at our own occupancy, never at downstream ready.
   assign in_ready = !w_full[w_dest];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr <= 1'b0;
      end else if (rr_en && in_valid && in_ready) begin
         r_rr <= ~r_rr;
      end
   end

   for (genvar k = 0; k < 2; k++) begin : g_fifo
      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [AW-1:0]    r_wp;
      logic [AW-1:0]    r_rp;
      logic [CW-1:0]    r_cnt;
      logic             w_push;
      logic             w_pop;

      assign w_push = in_valid & in_ready & (w_dest == 1'(k));
      assign w_pop  = (r_cnt != '0) & w_ordy[k];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
               r_mem[i] <= '0;
            end
         end else begin
            if (w_push) begin
               r_mem[r_wp] <= in_data;
               r_wp        <= r_wp + AW'(1);
            end
            if (w_pop) begin
               r_rp <= r_rp + AW'(1);
            end
            if (w_push && !w_pop) begin
               r_cnt <= r_cnt + CW'(1);
            end else if (w_pop && !w_push) begin
               r_cnt <= r_cnt - CW'(1);
            end
         end
      end

      assign w_full[k] = (r_cnt == CW'(DEPTH));
      assign w_cnt[k]  = r_cnt;
      assign w_head[k] = r_mem[r_rp];
   end

   assign count0     = w_cnt[0];
   assign count1     = w_cnt[1];
   assign out0_valid = (w_cnt[0] != '0);
   assign out1_valid = (w_cnt[1] != '0);
   assign out0_data  = w_head[0];
   assign out1_data  = w_head[1];

endmodule
